// File: rtl/mouse_pos_tracker.sv
// Cursor position tracker: accumulates signed mouse deltas into a clamped
// 12-bit X/Y position. Limits and position can be forced at any time.
module mouse_pos_tracker #(
  parameter int unsigned DEF_MAX_X = 1019,
  parameter int unsigned DEF_MAX_Y = 763
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] value,
  input  logic        setmax_x,
  input  logic        setmax_y,
  input  logic        setmin_x,
  input  logic        setmin_y,
  input  logic        set_x,
  input  logic        set_y,
  input  logic        move_valid,
  input  logic [8:0]  dx,
  input  logic [8:0]  dy,
  output logic        ready,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        pos_valid
);

  typedef enum logic [1:0] {IDLE, SUM, CLAMP, RECLAMP} state_t;

  localparam logic [11:0] RST_MAX_X = 12'(DEF_MAX_X);
  localparam logic [11:0] RST_MAX_Y = 12'(DEF_MAX_Y);
  localparam logic [11:0] RST_X     = 12'(DEF_MAX_X / 2);
  localparam logic [11:0] RST_Y     = 12'(DEF_MAX_Y / 2);

  state_t state, state_nxt;

  logic [11:0] max_x, max_y, min_x, min_y;
  logic [11:0] eff_max_x, eff_max_y, eff_min_x, eff_min_y;
  logic [8:0]  dx_q, dy_q;
  logic signed [13:0] sx_q, sy_q;
  logic        lim_pend;
  logic        any_lim, any_set, mv_take;

  assign any_lim = setmax_x | setmax_y | setmin_x | setmin_y;
  assign any_set = set_x | set_y;
  assign mv_take = move_valid && ready && !any_set;

  // Limits as they will be after this edge, so a same-cycle strobe is honoured
  // by CLAMP, RECLAMP and set_x/set_y without a follow-up RECLAMP.
  assign eff_max_x = setmax_x ? value : max_x;
  assign eff_max_y = setmax_y ? value : max_y;
  assign eff_min_x = setmin_x ? value : min_x;
  assign eff_min_y = setmin_y ? value : min_y;

  // Sums are 14 bits wide so xpos+dx can never wrap before clamping.
  function automatic logic [11:0] clamp(input logic signed [13:0] s,
                                        input logic [11:0] lo,
                                        input logic [11:0] hi);
    if ((s < $signed({2'b00, lo})) || (lo > hi)) return lo;
    else if (s > $signed({2'b00, hi}))           return hi;
    else                                         return s[11:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (any_set) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (mv_take)       state_nxt = SUM;
                 else if (lim_pend) state_nxt = RECLAMP;
        SUM:     state_nxt = CLAMP;
        CLAMP:   state_nxt = IDLE;
        RECLAMP: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_x     <= RST_MAX_X;
      max_y     <= RST_MAX_Y;
      min_x     <= '0;
      min_y     <= '0;
      xpos      <= RST_X;
      ypos      <= RST_Y;
      dx_q      <= '0;
      dy_q      <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      lim_pend  <= 1'b0;
      pos_valid <= 1'b0;
    end else begin
      max_x <= eff_max_x;
      max_y <= eff_max_y;
      min_x <= eff_min_x;
      min_y <= eff_min_y;

      // Only strobes seen while idle need a RECLAMP; an in-flight move's
      // CLAMP already applies them.
      lim_pend  <= any_lim && (state == IDLE) && !mv_take && !any_set;
      pos_valid <= any_set || (state == CLAMP) || (state == RECLAMP);

      if (mv_take) begin
        dx_q <= dx;
        dy_q <= dy;
      end

      if (state == SUM) begin
        sx_q <= $signed({2'b00, xpos}) + $signed({{5{dx_q[8]}}, dx_q});
        sy_q <= $signed({2'b00, ypos}) - $signed({{5{dy_q[8]}}, dy_q});
      end

      if (set_x)
        xpos <= clamp($signed({2'b00, value}), eff_min_x, eff_max_x);
      else if (!any_set && state == CLAMP)
        xpos <= clamp(sx_q, eff_min_x, eff_max_x);
      else if (!any_set && state == RECLAMP)
        xpos <= clamp($signed({2'b00, xpos}), eff_min_x, eff_max_x);

      if (set_y)
        ypos <= clamp($signed({2'b00, value}), eff_min_y, eff_max_y);
      else if (!any_set && state == CLAMP)
        ypos <= clamp(sy_q, eff_min_y, eff_max_y);
      else if (!any_set && state == RECLAMP)
        ypos <= clamp($signed({2'b00, ypos}), eff_min_y, eff_max_y);
    end
  end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed and randomized checks of mouse_pos_tracker against an integer
// model of cursor position and limits.
module tb_mouse_pos_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] value = '0;
  logic        setmax_x = 1'b0, setmax_y = 1'b0, setmin_x = 1'b0, setmin_y = 1'b0;
  logic        set_x = 1'b0, set_y = 1'b0;
  logic        move_valid = 1'b0;
  logic [8:0]  dx = '0, dy = '0;
  logic        ready;
  logic [11:0] xpos, ypos;
  logic        pos_valid;

  int checks = 0;
  int failures = 0;

  int m_min_x, m_max_x, m_min_y, m_max_y, m_x, m_y;

  mouse_pos_tracker #(.DEF_MAX_X(1019), .DEF_MAX_Y(763)) dut (
    .clk(clk), .rst(rst), .value(value),
    .setmax_x(setmax_x), .setmax_y(setmax_y), .setmin_x(setmin_x), .setmin_y(setmin_y),
    .set_x(set_x), .set_y(set_y), .move_valid(move_valid), .dx(dx), .dy(dy),
    .ready(ready), .xpos(xpos), .ypos(ypos), .pos_valid(pos_valid)
  );

  always #5 clk = ~clk;

  function automatic int clampm(int s, int lo, int hi);
    if (lo > hi) return lo;
    if (s < lo)  return lo;
    if (s > hi)  return hi;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag);
    check({tag, ".x"}, 32'(xpos), 32'(m_x));
    check({tag, ".y"}, 32'(ypos), 32'(m_y));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_min_x = 0; m_max_x = 1019; m_min_y = 0; m_max_y = 763;
    m_x = 509; m_y = 381;
    check("rst.ready", 32'(ready), 1);
    check("rst.pv", 32'(pos_valid), 0);
    check_pos("rst");
  endtask

  task automatic do_move(input string tag, input int ddx, input int ddy);
    logic [31:0] tmp;
    check({tag, ".rdy0"}, 32'(ready), 1);
    tmp = 32'(ddx); dx = tmp[8:0];
    tmp = 32'(ddy); dy = tmp[8:0];
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    check({tag, ".rdy_sum"}, 32'(ready), 0);
    tick();
    check({tag, ".rdy_clamp"}, 32'(ready), 0);
    check({tag, ".pv_early"}, 32'(pos_valid), 0);
    tick();
    m_x = clampm(m_x + ddx, m_min_x, m_max_x);
    m_y = clampm(m_y - ddy, m_min_y, m_max_y);
    check({tag, ".pv"}, 32'(pos_valid), 1);
    check_pos(tag);
    tick();
    check({tag, ".pv_end"}, 32'(pos_valid), 0);
    check({tag, ".rdy_end"}, 32'(ready), 1);
  endtask

  // which: 0=min_x 1=max_x 2=min_y 3=max_y
  task automatic set_lim(input string tag, input int which, input int v);
    value = 12'(v);
    setmin_x = (which == 0); setmax_x = (which == 1);
    setmin_y = (which == 2); setmax_y = (which == 3);
    tick();
    {setmin_x, setmax_x, setmin_y, setmax_y} = '0;
    case (which)
      0: m_min_x = v;
      1: m_max_x = v;
      2: m_min_y = v;
      default: m_max_y = v;
    endcase
    tick();
    check({tag, ".pv_pre"}, 32'(pos_valid), 0);
    tick();
    m_x = clampm(m_x, m_min_x, m_max_x);
    m_y = clampm(m_y, m_min_y, m_max_y);
    check({tag, ".pv"}, 32'(pos_valid), 1);
    check_pos(tag);
    tick();
    check({tag, ".pv_end"}, 32'(pos_valid), 0);
  endtask

  task automatic do_set(input string tag, input logic sx, input logic sy, input int v);
    value = 12'(v);
    set_x = sx; set_y = sy;
    tick();
    set_x = 1'b0; set_y = 1'b0;
    if (sx) m_x = clampm(v, m_min_x, m_max_x);
    if (sy) m_y = clampm(v, m_min_y, m_max_y);
    check({tag, ".pv"}, 32'(pos_valid), 1);
    check_pos(tag);
    tick();
    check({tag, ".pv_end"}, 32'(pos_valid), 0);
  endtask

  initial begin
    int r;
    do_reset();

    // Basic move: right 10, up 5
    do_move("mv1", 10, 5);

    // Window limits, then large negative/positive deltas
    set_lim("lminx", 0, 361);
    set_lim("lmaxx", 1, 645);
    set_lim("lminy", 2, 367);
    set_lim("lmaxy", 3, 651);
    do_set("setx511", 1'b1, 1'b0, 511);
    do_set("sety460", 1'b0, 1'b1, 460);
    do_move("mvneg", -256, 0);
    do_move("mvpos1", 255, 0);
    do_move("mvpos2", 255, 0);

    // Lowering max while idle reclamps
    do_reset();
    set_lim("max400", 1, 400);

    // set_x during SUM aborts the move
    do_reset();
    dx = 9'd50; dy = 9'd20; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    value = 12'd100; set_x = 1'b1;
    tick();
    set_x = 1'b0;
    m_x = 100;
    check("abort.pv", 32'(pos_valid), 1);
    check("abort.rdy", 32'(ready), 1);
    check_pos("abort");
    tick();
    check("abort.pv2", 32'(pos_valid), 0);
    check_pos("abort2");
    tick();
    check("abort.pv3", 32'(pos_valid), 0);

    // Limit strobe in CLAMP cycle is used by that CLAMP, no RECLAMP after
    do_reset();
    dx = 9'd91; dy = 9'd0; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    tick();
    value = 12'd800; setmin_x = 1'b1;
    tick();
    setmin_x = 1'b0;
    m_min_x = 800; m_x = 800;
    check("clmin.pv", 32'(pos_valid), 1);
    check_pos("clmin");
    tick();
    check("clmin.pv2", 32'(pos_valid), 0);
    tick();
    check("clmin.pv3", 32'(pos_valid), 0);
    check("clmin.rdy", 32'(ready), 1);
    set_lim("minmax", 1, 700);

    // Reset during CLAMP discards the move
    do_reset();
    dx = 9'd30; dy = 9'd30; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstcl.pv", 32'(pos_valid), 0);
    check("rstcl.rdy", 32'(ready), 1);
    check_pos("rstcl");
    tick();
    check("rstcl.pv2", 32'(pos_valid), 0);
    check_pos("rstcl2");

    // Extremes: no wrap at 4095 or below 0
    set_lim("max4095x", 1, 4095);
    set_lim("max4095y", 3, 4095);
    do_set("set4095", 1'b1, 1'b1, 4095);
    do_move("top", 255, -256);
    do_set("set0", 1'b1, 1'b1, 0);
    do_move("bot", -256, 255);
    check("ignore.rdy", 32'(ready), 1);

    // Randomized mix of moves, limit updates and forced positions
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)
        do_move("rmove", int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
      else if (r <= 7)
        set_lim("rlim", int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
      else
        do_set("rset", 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 4095)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
